skl_32_sub_seq_8: RTL and testbench

- Sequential 32-bit unsigned/two's-complement subtractor: computes s = x1 - x2 - bin.
- Processes one 8-bit slice per clock through a single Sklansky-8 add core (x1 + ~x2 + ~borrow), registering the borrow between slices.
- Counterpart to the ripple-of-Sklansky-8 adder datapath.
- Trades latency for area: one 8-bit prefix core instead of four, with a start/done handshake for the sequencer that owns the ALU.

---
 rtl/skl_32_sub_seq_8.sv | 145 ++++++++++++++
 tb/tb_skl_32_sub_seq_8.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/skl_32_sub_seq_8.sv
// Sequential subtractor: x1 - x2 - bin, one BLOCK-bit slice per clock through a
// single Sklansky prefix adder computing x1 + ~x2 + ~borrow.
module skl_32_sub_seq_8 #(
  parameter  int WIDTH = 32,
  parameter  int BLOCK = 8,
  localparam int NBLK  = WIDTH / BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             bout,
  output logic             ovf
);

  localparam int LVL  = $clog2(BLOCK);
  localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x1_q, x1_d, x2_q, x2_d, work_q, work_d, s_q, s_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             c_q, c_d, sx1_q, sx1_d, sx2_q, sx2_d;
  logic             bout_q, bout_d, ovf_q, ovf_d;

  // Slice core: operands shift right each cycle, so the active slice is always the low BLOCK bits.
  logic [BLOCK-1:0] a_sl, b_sl, g_sl, p_sl, gg, pp, sum_sl;
  logic [BLOCK:0]   cy;
  int               j;

  always_comb begin
    a_sl = x1_q[BLOCK-1:0];
    b_sl = ~x2_q[BLOCK-1:0];
    g_sl = a_sl & b_sl;
    p_sl = a_sl ^ b_sl;
    gg   = g_sl;
    pp   = p_sl;
    j    = 0;
    // Sklansky levels; the partner index never has bit l set, so in-place update is safe.
    for (int l = 0; l < LVL; l++) begin
      for (int i = 0; i < BLOCK; i++) begin
        if (((i >> l) & 1) == 1) begin
          j     = ((i >> l) << l) - 1;
          gg[i] = gg[i] | (pp[i] & gg[j]);
          pp[i] = pp[i] & pp[j];
        end
      end
    end
    cy[0] = c_q;
    for (int i = 0; i < BLOCK; i++) begin
      cy[i+1] = gg[i] | (pp[i] & c_q);
    end
    sum_sl = p_sl ^ cy[BLOCK-1:0];
  end

  always_comb begin
    state_d = state_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    work_d  = work_q;
    idx_d   = idx_q;
    c_d     = c_q;
    sx1_d   = sx1_q;
    sx2_d   = sx2_q;
    s_d     = s_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x1_d    = x1;
          x2_d    = x2;
          sx1_d   = x1[WIDTH-1];
          sx2_d   = x2[WIDTH-1];
          c_d     = ~bin;
          idx_d   = '0;
          work_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        x1_d   = x1_q >> BLOCK;
        x2_d   = x2_q >> BLOCK;
        c_d    = cy[BLOCK];
        work_d = {sum_sl, work_q[WIDTH-1:BLOCK]};
        idx_d  = idx_q + IDXW'(1);
        if (idx_q == IDXW'(NBLK - 1)) begin
          // Results are registered on the edge entering DONE so they show during DONE.
          idx_d   = '0;
          s_d     = {sum_sl, work_q[WIDTH-1:BLOCK]};
          bout_d  = ~cy[BLOCK];
          ovf_d   = (sx1_q ^ sx2_q) & (sum_sl[BLOCK-1] ^ sx1_q);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x1_q    <= '0;
      x2_q    <= '0;
      work_q  <= '0;
      idx_q   <= '0;
      c_q     <= 1'b0;
      sx1_q   <= 1'b0;
      sx2_q   <= 1'b0;
      s_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      work_q  <= work_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      sx1_q   <= sx1_d;
      sx2_q   <= sx2_d;
      s_q     <= s_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign s    = s_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_skl_32_sub_seq_8.sv
// Directed bench for skl_32_sub_seq_8: arithmetic vectors, handshake timing,
// ignored starts, back-to-back issue and mid-operation reset.
module tb_skl_32_sub_seq_8;

  logic        clk = 1'b0;
  logic        rst, start, bin;
  logic [31:0] x1, x2;
  logic        busy, done, bout, ovf;
  logic [31:0] s;

  int checks = 0;
  int failures = 0;

  skl_32_sub_seq_8 dut (
    .clk(clk), .rst(rst), .start(start), .x1(x1), .x2(x2), .bin(bin),
    .busy(busy), .done(done), .s(s), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Issue one op: start seen at edge T, then operands are scrambled.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic bi);
    @(negedge clk);
    x1 = a; x2 = b; bin = bi; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x1 = $urandom; x2 = $urandom; bin = 1'($urandom_range(0, 1));
  endtask

  // Record busy/done at negedges of cycles T+1..T+n.
  task automatic watch(input int n, output logic [15:0] bh, output logic [15:0] dh);
    bh = '0; dh = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      bh[k-1] = busy;
      dh[k-1] = done;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; x1 = '0; x2 = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, bout, ovf} !== 4'b0000 || s !== 32'h0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b s=%h bout=%b ovf=%b required all zero", busy, done, s, bout, ovf);
    end
    rst = 1'b0;
    $display("reset: busy=%b done=%b s=%h", busy, done, s);
  endtask

  task automatic test_vec(input string nm, input logic [31:0] a, input logic [31:0] b, input logic bi,
                          input logic [31:0] es, input logic eb, input logic eo);
    logic [15:0] bh, dh;
    start_op(a, b, bi);
    watch(8, bh, dh);
    checks++;
    if (dh !== 16'h0010) begin
      failures++;
      $display("FAIL %s done timing: got %h required 0010", nm, dh);
    end
    checks++;
    if (bh !== 16'h001F) begin
      failures++;
      $display("FAIL %s busy timing: got %h required 001f", nm, bh);
    end
    checks++;
    if (s !== es || bout !== eb || ovf !== eo) begin
      failures++;
      $display("FAIL %s result: s=%h bout=%b ovf=%b required s=%h bout=%b ovf=%b", nm, s, bout, ovf, es, eb, eo);
    end
    $display("%s: %h - %h - %b -> s=%h bout=%b ovf=%b", nm, a, b, bi, s, bout, ovf);
  endtask

  task automatic test_ignore_start;
    logic [15:0] bh, dh;
    bh = '0; dh = '0;
    start_op(32'h00001000, 32'h00000001, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bh[k-1] = busy; dh[k-1] = done;
      if (k == 2) begin
        start = 1'b1; x1 = 32'hFFFFFFFF; x2 = 32'h0; bin = 1'b1;
      end
      if (k == 3) start = 1'b0;
    end
    checks++;
    if (dh !== 16'h0010 || bh !== 16'h001F) begin
      failures++;
      $display("FAIL ignore_start timing: done=%h busy=%h required 0010/001f", dh, bh);
    end
    checks++;
    if (s !== 32'h00000FFF || bout !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL ignore_start result: s=%h bout=%b ovf=%b required 00000fff 0 0", s, bout, ovf);
    end
    $display("ignore_start: s=%h done=%h", s, dh);
  endtask

  task automatic test_back_to_back;
    logic [15:0] bh, dh;
    logic [31:0] sa;
    logic        ba;
    bh = '0; dh = '0; sa = '0; ba = 1'b0;
    @(negedge clk);
    x1 = 32'h00000010; x2 = 32'h00000003; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    x1 = 32'h00000001; x2 = 32'h00000002; bin = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      bh[k-1] = busy; dh[k-1] = done;
      if (k == 5) begin
        sa = s; ba = bout;
      end
      if (k == 11) start = 1'b0;
    end
    checks++;
    if (dh !== 16'h0410 || bh !== 16'h07DF) begin
      failures++;
      $display("FAIL back_to_back timing: done=%h busy=%h required 0410/07df", dh, bh);
    end
    checks++;
    if (sa !== 32'h0000000D || ba !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back first: s=%h bout=%b required 0000000d 0", sa, ba);
    end
    checks++;
    if (s !== 32'hFFFFFFFF || bout !== 1'b1 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back second: s=%h bout=%b ovf=%b required ffffffff 1 0", s, bout, ovf);
    end
    repeat (2) @(negedge clk);
    $display("back_to_back: first=%h second=%h", sa, s);
  endtask

  task automatic test_reset_mid;
    logic [15:0] bh, dh;
    start_op(32'h00000005, 32'h00000003, 1'b0);
    for (int k = 1; k <= 3; k++) @(negedge clk);
    rst = 1'b1; start = 1'b1; x1 = 32'h11111111; x2 = 32'h0; bin = 1'b0;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checks++;
    if ({busy, done, bout, ovf} !== 4'b0000 || s !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid clear: busy=%b done=%b s=%h bout=%b ovf=%b required all zero", busy, done, s, bout, ovf);
    end
    watch(8, bh, dh);
    checks++;
    if (dh !== 16'h0 || bh !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid after: done=%h busy=%h required 0000/0000", dh, bh);
    end
    $display("reset_mid: busy=%b s=%h", busy, s);
    test_vec("post_reset", 32'h0000ABCD, 32'h00001234, 1'b1, 32'h00009998, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_vec("basic",     32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0);
    test_vec("ripple",    32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
    test_vec("ovf_neg",   32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
    test_vec("ovf_pos",   32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1);
    test_vec("equal_bin", 32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    test_vec("slice01",   32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0);
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
